// File: rtl/cmult_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmult_arbiter: two requesters share one pipelined complex multiply  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+

module complex_mult #(
  parameter int DINA_WIDTH = 8,
  parameter int DINB_WIDTH = 8,
  parameter int MULT_WIDTH = DINA_WIDTH + DINB_WIDTH + 2
) (
  input  logic [DINA_WIDTH-1:0] a_i,
  input  logic [DINA_WIDTH-1:0] a_q,
  input  logic [DINB_WIDTH-1:0] b_i,
  input  logic [DINB_WIDTH-1:0] b_q,
  output logic [MULT_WIDTH-1:0] mult_i,
  output logic [MULT_WIDTH-1:0] mult_q
);

  logic signed [MULT_WIDTH-1:0] ai_x;
  logic signed [MULT_WIDTH-1:0] aq_x;
  logic signed [MULT_WIDTH-1:0] bi_x;
  logic signed [MULT_WIDTH-1:0] bq_x;

  // Sign-extend every operand to the result width so the arithmetic is exact.
  assign ai_x = $signed({{(MULT_WIDTH-DINA_WIDTH){a_i[DINA_WIDTH-1]}}, a_i});
  assign aq_x = $signed({{(MULT_WIDTH-DINA_WIDTH){a_q[DINA_WIDTH-1]}}, a_q});
  assign bi_x = $signed({{(MULT_WIDTH-DINB_WIDTH){b_i[DINB_WIDTH-1]}}, b_i});
  assign bq_x = $signed({{(MULT_WIDTH-DINB_WIDTH){b_q[DINB_WIDTH-1]}}, b_q});

  assign mult_i = ai_x * bi_x - aq_x * bq_x;
  assign mult_q = ai_x * bq_x + aq_x * bi_x;

endmodule

module cmult_arbiter #(
  parameter int DINA_WIDTH = 8,
  parameter int DINB_WIDTH = 8,
  parameter int MULT_WIDTH = DINA_WIDTH + DINB_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DINA_WIDTH-1:0] req0_a_i,
  input  logic [DINA_WIDTH-1:0] req0_a_q,
  input  logic [DINB_WIDTH-1:0] req0_b_i,
  input  logic [DINB_WIDTH-1:0] req0_b_q,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DINA_WIDTH-1:0] req1_a_i,
  input  logic [DINA_WIDTH-1:0] req1_a_q,
  input  logic [DINB_WIDTH-1:0] req1_b_i,
  input  logic [DINB_WIDTH-1:0] req1_b_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MULT_WIDTH-1:0] out_i,
  output logic [MULT_WIDTH-1:0] out_q,
  output logic                  out_id,
  output logic [15:0]           cnt0,
  output logic [15:0]           cnt1
);

  logic                  last_grant;
  logic                  grant_valid;
  logic                  grant_id;
  logic                  s1_valid;
  logic                  s1_adv;
  logic                  s1_can_load;
  logic                  xfer;
  logic                  s1_id;
  logic [DINA_WIDTH-1:0] s1_a_i;
  logic [DINA_WIDTH-1:0] s1_a_q;
  logic [DINB_WIDTH-1:0] s1_b_i;
  logic [DINB_WIDTH-1:0] s1_b_q;
  logic [DINA_WIDTH-1:0] sel_a_i;
  logic [DINA_WIDTH-1:0] sel_a_q;
  logic [DINB_WIDTH-1:0] sel_b_i;
  logic [DINB_WIDTH-1:0] sel_b_q;
  logic [MULT_WIDTH-1:0] mult_i;
  logic [MULT_WIDTH-1:0] mult_q;

  assign s1_adv      = s1_valid && (!out_valid || out_ready);
  assign s1_can_load = !s1_valid || s1_adv;

  // On contention the requester that did not last complete a transfer wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign xfer       = !rst && grant_valid && s1_can_load;
  assign req0_ready = xfer && (grant_id == 1'b0);
  assign req1_ready = xfer && (grant_id == 1'b1);

  always_comb begin
    sel_a_i = req0_a_i;
    sel_a_q = req0_a_q;
    sel_b_i = req0_b_i;
    sel_b_q = req0_b_q;
    if (grant_id) begin
      sel_a_i = req1_a_i;
      sel_a_q = req1_a_q;
      sel_b_i = req1_b_i;
      sel_b_q = req1_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_a_i   <= '0;
      s1_a_q   <= '0;
      s1_b_i   <= '0;
      s1_b_q   <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_id    <= grant_id;
      s1_a_i   <= sel_a_i;
      s1_a_q   <= sel_a_q;
      s1_b_i   <= sel_b_i;
      s1_b_q   <= sel_b_q;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  complex_mult #(
    .DINA_WIDTH (DINA_WIDTH),
    .DINB_WIDTH (DINB_WIDTH),
    .MULT_WIDTH (MULT_WIDTH)
  ) u_cmult (
    .a_i    (s1_a_i),
    .a_q    (s1_a_q),
    .b_i    (s1_b_i),
    .b_q    (s1_b_q),
    .mult_i (mult_i),
    .mult_q (mult_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_id    <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_i     <= mult_i;
      out_q     <= mult_q;
      out_id    <= s1_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cnt0       <= 16'd0;
      cnt1       <= 16'd0;
    end else begin
      if (xfer) begin
        last_grant <= grant_id;
      end
      if (req0_ready) begin
        cnt0 <= cnt0 + 16'd1;
      end
      if (req1_ready) begin
        cnt1 <= cnt1 + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmult_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cmult_arbiter: directed self-checking bench for cmult_arbiter    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+

module tb_cmult_arbiter;

  localparam int AW = 8;
  localparam int BW = 8;
  localparam int MW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [AW-1:0] req0_a_i, req0_a_q;
  logic [BW-1:0] req0_b_i, req0_b_q;
  logic          req1_valid, req1_ready;
  logic [AW-1:0] req1_a_i, req1_a_q;
  logic [BW-1:0] req1_b_i, req1_b_q;
  logic          out_valid, out_ready;
  logic [MW-1:0] out_i, out_q;
  logic          out_id;
  logic [15:0]   cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmult_arbiter #(
    .DINA_WIDTH (AW),
    .DINB_WIDTH (BW),
    .MULT_WIDTH (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a_i   (req0_a_i),
    .req0_a_q   (req0_a_q),
    .req0_b_i   (req0_b_i),
    .req0_b_q   (req0_b_q),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a_i   (req1_a_i),
    .req1_a_q   (req1_a_q),
    .req1_b_i   (req1_b_i),
    .req1_b_q   (req1_b_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_id     (out_id),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input int ai, input int aq,
                         input int bi, input int bq, input logic v);
    if (id == 0) begin
      req0_a_i = AW'(ai); req0_a_q = AW'(aq);
      req0_b_i = BW'(bi); req0_b_q = BW'(bq);
      req0_valid = v;
    end else begin
      req1_a_i = AW'(ai); req1_a_q = AW'(aq);
      req1_b_i = BW'(bi); req1_b_q = BW'(bq);
      req1_valid = v;
    end
  endtask

  function automatic int oi();
    oi = $signed(out_i);
  endfunction

  function automatic int oq();
    oq = $signed(out_q);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 1'b1);
    set_req(1, 0, 0, 0, 0, 1'b1);
    tick();
    // Ready must stay low while reset is held, even with valid requests.
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 1'b0);
    set_req(1, 0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_i", oi(), 0);
    check("rst_out_q", oq(), 0);
    check("rst_out_id", out_id, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);

    // Single request (3+4j)x(5+2j)
    set_req(0, 3, 4, 5, 2, 1'b1);
    #1;
    check("single_rdy0", req0_ready, 1);
    tick();
    set_req(0, 0, 0, 0, 0, 1'b0);
    check("single_lat1_valid", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_i", oi(), 7);
    check("single_q", oq(), 26);
    check("single_id", out_id, 0);
    check("single_cnt0", cnt0, 1);
    tick();
    check("single_drain", out_valid, 0);

    // Contention after reset: alternate 0,1,0,1,...
    do_reset();
    set_req(0, 1, 0, 2, 0, 1'b1);
    set_req(1, 1, 0, 3, 0, 1'b1);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("cont_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      check("cont_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      if (i >= 1) begin
        check("cont_valid", out_valid, 1);
        check("cont_id", out_id, (i - 1) % 2);
        check("cont_i", oi(), ((i - 1) % 2 == 1) ? 3 : 2);
      end
    end
    check("cont_cnt0", cnt0, 3);
    check("cont_cnt1", cnt1, 3);
    set_req(0, 0, 0, 0, 0, 1'b0);
    set_req(1, 0, 0, 0, 0, 1'b0);
    tick(); tick(); tick();
    check("cont_drain", out_valid, 0);

    // Backpressure with both stages full
    set_req(0, 2, 1, 3, 0, 1'b1);
    tick();
    set_req(0, 0, 0, 0, 0, 1'b0);
    set_req(1, 1, 1, 1, -1, 1'b1);
    tick();
    set_req(1, 0, 0, 0, 0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(0, k + 10, k, 7, 7, 1'b1);
      #1;
      check("bp_rdy0", req0_ready, 0);
      check("bp_rdy1", req1_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_i", oi(), 6);
      check("bp_q", oq(), 3);
      check("bp_id", out_id, 0);
      tick();
    end
    set_req(0, -5, 0, 4, 0, 1'b1);
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy0", req0_ready, 1);
    tick();
    set_req(0, 0, 0, 0, 0, 1'b0);
    check("bp_b_i", oi(), 2);
    check("bp_b_q", oq(), 0);
    check("bp_b_id", out_id, 1);
    tick();
    check("bp_c_valid", out_valid, 1);
    check("bp_c_i", oi(), -20);
    check("bp_c_id", out_id, 0);
    tick();
    check("bp_empty", out_valid, 0);

    // Extreme operands at 8-bit widths
    set_req(0, -128, -128, -128, -128, 1'b1);
    tick();
    set_req(0, 0, 0, 0, 0, 1'b0);
    set_req(1, 127, -128, 127, 127, 1'b1);
    tick();
    set_req(1, 0, 0, 0, 0, 1'b0);
    check("ext1_i", oi(), 0);
    check("ext1_q", oq(), 32768);
    tick();
    check("ext2_i", oi(), 32385);
    check("ext2_q", oq(), -127);
    tick();

    // Reset mid-flight
    set_req(0, 1, 0, 1, 0, 1'b1);
    tick();
    tick();
    check("mid_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy0", req0_ready, 0);
    tick();
    check("mid_valid", out_valid, 0);
    check("mid_cnt0", cnt0, 0);
    check("mid_cnt1", cnt1, 0);
    rst = 1'b0;
    set_req(0, 1, 0, 7, 0, 1'b1);
    set_req(1, 1, 0, 9, 0, 1'b1);
    #1;
    check("mid_first_rdy0", req0_ready, 1);
    check("mid_first_rdy1", req1_ready, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 1'b0);
    set_req(1, 0, 0, 0, 0, 1'b0);
    check("mid_no_stale", out_valid, 0);
    tick();
    check("mid_new_valid", out_valid, 1);
    check("mid_new_id", out_id, 0);
    check("mid_new_i", oi(), 7);
    tick();
    check("mid_done", out_valid, 0);

    // Counter wrap on requester 1
    do_reset();
    set_req(1, 1, 0, 1, 0, 1'b1);
    for (int n = 0; n < 65535; n++) begin
      tick();
    end
    check("wrap_pre", cnt1, 65535);
    check("wrap_cnt0", cnt0, 0);
    tick();
    check("wrap_cnt1", cnt1, 0);
    set_req(1, 0, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
